// File: rtl/fmwq_pkg.sv
// Shared types and default constants for the FM2151 host write queue.
package fmwq_pkg;

    localparam int unsigned FmwqDepthLog2 = 4;
    localparam int unsigned FmwqWrPulse   = 14;
    localparam int unsigned FmwqBusyWait  = 896;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StGap,
        StData,
        StWait
    } fmwq_state_e;

    // Queue entry: OPM register address in [15:8], register data in [7:0].
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } fmwq_entry_t;

    function automatic int unsigned fmwq_cnt_width(int unsigned a, int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/fmwq_fifo.sv
// Synchronous FIFO of address/data entries with a registered read port.
module fmwq_fifo
    import fmwq_pkg::*;
#(
    parameter int unsigned DepthLog2 = FmwqDepthLog2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  fmwq_entry_t        wr_data,
    input  logic               pop,
    output fmwq_entry_t        rd_data,
    output logic               full,
    output logic               empty,
    output logic [DepthLog2:0] level
);

    localparam int unsigned Depth = 1 << DepthLog2;
    localparam logic [DepthLog2:0]   LevelFull = (DepthLog2 + 1)'(Depth);
    localparam logic [DepthLog2:0]   LevelOne  = (DepthLog2 + 1)'(1);
    localparam logic [DepthLog2-1:0] PtrOne    = DepthLog2'(1);

    fmwq_entry_t          mem_q [Depth];
    fmwq_entry_t          rd_data_q;
    logic [DepthLog2-1:0] wr_ptr_q;
    logic [DepthLog2-1:0] rd_ptr_q;
    logic [DepthLog2:0]   level_q;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (level_q == LevelFull);
    assign empty   = (level_q == '0);
    assign do_pop  = pop && !empty;
    // A full queue still accepts a push when the same edge frees a slot.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (do_pop) begin
                rd_data_q <= mem_q[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + PtrOne;
            end
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LevelOne;
                2'b01:   level_q <= level_q - LevelOne;
                default: level_q <= level_q;
            endcase
        end
    end

    assign rd_data = rd_data_q;
    assign level   = level_q;

endmodule

// File: rtl/fm_write_queue.sv
// Host write buffer that replays queued YM2151 writes into the OPM CPU port.
// Optional build macro FMWQ_BUSY_POLL_EN: end the post-write wait early on OPM not-busy.
module fm_write_queue
    import fmwq_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = FmwqDepthLog2,
    parameter int unsigned WR_PULSE   = FmwqWrPulse,
    parameter int unsigned BUSY_WAIT  = FmwqBusyWait
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            slv_addr_i,
    input  logic [7:0]            slv_datawr_i,
    input  logic                  slv_datawr_valid,
    input  logic                  slv_req_i,
    input  logic                  slv_rwn_i,
    output logic [7:0]            slv_datard_o,
    output logic                  opm_cs_n,
    output logic                  opm_wr_n,
    output logic                  opm_a0,
    output logic [7:0]            opm_d,
    input  logic [7:0]            opm_status_i,
    output logic [DEPTH_LOG2:0]   fifo_level_o
);

    localparam int unsigned CntW = fmwq_cnt_width(BUSY_WAIT, WR_PULSE);
    localparam logic [CntW-1:0] PulseLoad = CntW'(WR_PULSE - 1);
    localparam logic [CntW-1:0] WaitLoad  = CntW'(BUSY_WAIT - 1);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);

    logic        host_acc;
    logic        host_wr;
    logic        host_rd;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        ovf_q;
    logic [7:0]  addr_hold_q;
    fmwq_entry_t wr_entry;
    fmwq_entry_t rd_entry;

    fmwq_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wait_done;

    assign host_acc = slv_req_i & slv_datawr_valid;
    assign host_wr  = host_acc & ~slv_rwn_i;
    assign host_rd  = host_acc & slv_rwn_i;
    assign push     = host_wr & slv_addr_i[0];

    assign wr_entry.addr = addr_hold_q;
    assign wr_entry.data = slv_datawr_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_hold_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            if (host_wr && !slv_addr_i[0]) begin
                addr_hold_q <= slv_datawr_i;
            end
            // A dropped push outranks a simultaneous status read.
            if (push && full && !pop) begin
                ovf_q <= 1'b1;
            end else if (host_rd) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign slv_datard_o = {full, ovf_q, 4'b0000, opm_status_i[1:0]};

    fmwq_fifo #(
        .DepthLog2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level_o)
    );

`ifdef FMWQ_BUSY_POLL_EN
    // Counter value at which WAIT has lasted 2*WR_PULSE cycles; BUSY_WAIT remains the cap.
    localparam logic [CntW-1:0] PollOpen = CntW'(BUSY_WAIT - 2 * WR_PULSE);
    assign wait_done = (cnt_q == '0) || ((cnt_q <= PollOpen) && !opm_status_i[7]);

    logic unused_in;
    assign unused_in = ^{slv_addr_i[4:1], opm_status_i[6:2]};
`else
    assign wait_done = (cnt_q == '0);

    logic unused_in;
    assign unused_in = ^{slv_addr_i[4:1], opm_status_i[7:2]};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StAddr;
                    cnt_d   = PulseLoad;
                end
            end
            StAddr: begin
                if (cnt_q == '0) begin
                    state_d = StGap;
                    cnt_d   = PulseLoad;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StData;
                    cnt_d   = PulseLoad;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StData: begin
                if (cnt_q == '0) begin
                    state_d = StWait;
                    cnt_d   = WaitLoad;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StWait: begin
                if (wait_done) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        opm_cs_n = 1'b1;
        opm_wr_n = 1'b1;
        opm_a0   = 1'b0;
        opm_d    = '0;
        unique case (state_q)
            StAddr: begin
                opm_cs_n = 1'b0;
                opm_wr_n = 1'b0;
                opm_d    = rd_entry.addr;
            end
            StGap: begin
                opm_d = rd_entry.addr;
            end
            StData: begin
                opm_cs_n = 1'b0;
                opm_wr_n = 1'b0;
                opm_a0   = 1'b1;
                opm_d    = rd_entry.data;
            end
            StWait: begin
                opm_a0 = 1'b1;
                opm_d  = rd_entry.data;
            end
            default: begin
                opm_cs_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_fm_write_queue.sv
// Self-checking bench for fm_write_queue: random writes against a timing/queue model.
module tb_fm_write_queue;

    localparam int Depth  = 16;
    localparam int Wp     = 14;
    localparam int Bw     = 896;
    localparam int Period = 3 * Wp + Bw + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] slv_addr_i = '0;
    logic [7:0] slv_datawr_i = '0;
    logic       slv_datawr_valid = 1'b0;
    logic       slv_req_i = 1'b0;
    logic       slv_rwn_i = 1'b0;
    logic [7:0] slv_datard_o;
    logic       opm_cs_n;
    logic       opm_wr_n;
    logic       opm_a0;
    logic [7:0] opm_d;
    logic [7:0] opm_status_i = 8'h80;
    logic [4:0] fifo_level_o;

    fm_write_queue dut (
        .clk              (clk),
        .reset            (reset),
        .slv_addr_i       (slv_addr_i),
        .slv_datawr_i     (slv_datawr_i),
        .slv_datawr_valid (slv_datawr_valid),
        .slv_req_i        (slv_req_i),
        .slv_rwn_i        (slv_rwn_i),
        .slv_datard_o     (slv_datard_o),
        .opm_cs_n         (opm_cs_n),
        .opm_wr_n         (opm_wr_n),
        .opm_a0           (opm_a0),
        .opm_d            (opm_d),
        .opm_status_i     (opm_status_i),
        .fifo_level_o     (fifo_level_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // Observed OPM strobes (low runs of cs_n/wr_n), sampled on the falling edge.
    typedef struct {
        bit         a0;
        logic [7:0] d;
        int         start;
        int         len;
        bit         stable;
    } strobe_t;
    strobe_t strobes[$];

    logic       run_on = 1'b0;
    logic       run_a0 = 1'b0;
    logic [7:0] run_d = '0;
    int         run_start = 0;
    int         run_len = 0;
    logic       run_stable = 1'b0;
    logic       skew_seen = 1'b0;

    always @(negedge clk) begin
        if (opm_cs_n !== opm_wr_n) skew_seen <= 1'b1;
        if (!opm_cs_n && !opm_wr_n) begin
            if (!run_on) begin
                run_on     <= 1'b1;
                run_start  <= cyc;
                run_len    <= 1;
                run_a0     <= opm_a0;
                run_d      <= opm_d;
                run_stable <= 1'b1;
            end else begin
                run_len <= run_len + 1;
                if (opm_a0 !== run_a0 || opm_d !== run_d) run_stable <= 1'b0;
            end
        end else if (run_on) begin
            run_on <= 1'b0;
            strobes.push_back('{a0: run_a0, d: run_d, start: run_start, len: run_len,
                                stable: run_stable});
        end
    end

    // Reference model: entries in order, the edge each is pushed and popped.
    int         push_e[$];
    int         pop_e[$];
    logic [7:0] exp_a[$];
    logic [7:0] exp_d[$];
    int         last_pop = -1000000;
    logic [7:0] m_addr = '0;
    bit         m_ovf = 1'b0;

    function automatic void model_reset();
        push_e.delete();
        pop_e.delete();
        exp_a.delete();
        exp_d.delete();
        last_pop = -1000000;
        m_addr   = '0;
        m_ovf    = 1'b0;
    endfunction

    function automatic int model_level(int t);
        int n = 0;
        foreach (push_e[i]) if (push_e[i] <= t) n++;
        foreach (pop_e[i]) if (pop_e[i] <= t) n--;
        return n;
    endfunction

    // Drain pops an entry one edge after it lands, and at most once per pair period.
    function automatic bit model_push(int e, logic [7:0] a, logic [7:0] d);
        int occ = 0;
        bit pop_now = 1'b0;
        int p;
        foreach (push_e[i]) if (push_e[i] < e) occ++;
        foreach (pop_e[i]) begin
            if (pop_e[i] < e) occ--;
            if (pop_e[i] == e) pop_now = 1'b1;
        end
        if (occ >= Depth && !pop_now) return 1'b0;
        p = (e + 1 > last_pop + Period) ? e + 1 : last_pop + Period;
        push_e.push_back(e);
        pop_e.push_back(p);
        exp_a.push_back(a);
        exp_d.push_back(d);
        last_pop = p;
        return 1'b1;
    endfunction

    task automatic host_write(input bit a0, input logic [7:0] d);
        int e;
        slv_req_i        = 1'b1;
        slv_datawr_valid = 1'b1;
        slv_rwn_i        = 1'b0;
        slv_addr_i       = {4'($urandom_range(0, 15)), a0};
        slv_datawr_i     = d;
        e = cyc + 1;
        if (!a0) m_addr = d;
        else if (!model_push(e, m_addr, d)) m_ovf = 1'b1;
        @(negedge clk);
        slv_req_i        = 1'b0;
        slv_datawr_valid = 1'b0;
    endtask

    task automatic host_read(output logic [7:0] v, output logic [7:0] expv);
        expv = {model_level(cyc) == Depth, m_ovf, 4'b0000, opm_status_i[1:0]};
        slv_req_i        = 1'b1;
        slv_datawr_valid = 1'b1;
        slv_rwn_i        = 1'b1;
        slv_addr_i       = 5'd1;
        #1 v = slv_datard_o;
        @(negedge clk);
        slv_req_i        = 1'b0;
        slv_datawr_valid = 1'b0;
        slv_rwn_i        = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic settle();
        while (cyc < last_pop + Period + 2) @(negedge clk);
        strobes.delete();
        push_e.delete();
        pop_e.delete();
        exp_a.delete();
        exp_d.delete();
    endtask

    task automatic wait_strobes(input string tag, input int n, input int budget);
        int lim = cyc + budget;
        while (strobes.size() < n && cyc < lim) @(negedge clk);
        @(negedge clk);
        total++;
        if (strobes.size() < n) begin
            bad++;
            $display("FAIL %s_timeout: got %0d strobes want %0d", tag, strobes.size(), n);
        end
    endtask

    task automatic check_replay(input string tag, input int n);
        logic [73:0] got, want;
        total++;
        if (strobes.size() != 2 * n) begin
            bad++;
            $display("FAIL %s_count: got %0d want %0d", tag, strobes.size(), 2 * n);
        end
        for (int i = 0; i < n; i++) begin
            got  = {strobes[2*i].a0, strobes[2*i].d, strobes[2*i].start, strobes[2*i].len,
                    strobes[2*i].stable};
            want = {1'b0, exp_a[i], pop_e[i], Wp, 1'b1};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s_addr%0d: got %h want %h", tag, i, got, want);
            end
            got  = {strobes[2*i+1].a0, strobes[2*i+1].d, strobes[2*i+1].start,
                    strobes[2*i+1].len, strobes[2*i+1].stable};
            want = {1'b1, exp_d[i], pop_e[i] + 2 * Wp, Wp, 1'b1};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s_data%0d: got %h want %h", tag, i, got, want);
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] st;
        repeat (3) @(negedge clk);
        st = {opm_cs_n, opm_wr_n, opm_a0, 5'b0};
        total++;
        if (st !== 8'hc0) begin
            bad++;
            $display("FAIL reset_strobes: got %h want %h", st, 8'hc0);
        end
        total++;
        if (opm_d !== 8'h00) begin
            bad++;
            $display("FAIL reset_opm_d: got %h want %h", opm_d, 8'h00);
        end
        total++;
        if (fifo_level_o !== 5'd0) begin
            bad++;
            $display("FAIL reset_level: got %0d want 0", fifo_level_o);
        end
        total++;
        if (slv_datard_o !== 8'h00) begin
            bad++;
            $display("FAIL reset_status: got %h want %h", slv_datard_o, 8'h00);
        end
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        // addr_hold resets to zero: a data write alone targets register 0.
        host_write(1'b1, 8'h5c);
        wait_strobes("reset_addr", 2, Period + 50);
        check_replay("reset_addr", 1);
    endtask

    task automatic test_single();
        settle();
        host_write(1'b0, 8'h28);
        host_write(1'b1, 8'h4a);
        total++;
        if (fifo_level_o !== 5'(model_level(cyc))) begin
            bad++;
            $display("FAIL single_level: got %0d want %0d", fifo_level_o, model_level(cyc));
        end
        host_write(1'b0, 8'($urandom));
        host_write(1'b1, 8'($urandom));
        wait_strobes("single", 4, 2 * Period + 50);
        check_replay("single", 2);
    endtask

    task automatic test_burst();
        logic [7:0] v, expv;
        settle();
        for (int i = 0; i < Depth + 1; i++) begin
            host_write(1'b0, 8'($urandom));
            host_write(1'b1, 8'($urandom));
            total++;
            if ({slv_datard_o[7], fifo_level_o} !== {model_level(cyc) == Depth,
                                                     5'(model_level(cyc))}) begin
                bad++;
                $display("FAIL burst_level%0d: got full=%b level=%0d want level=%0d", i,
                         slv_datard_o[7], fifo_level_o, model_level(cyc));
            end
        end
        host_write(1'b0, 8'($urandom));
        host_write(1'b1, 8'($urandom));
        total++;
        if ({slv_datard_o[7:6], fifo_level_o} !== {1'b1, m_ovf, 5'(model_level(cyc))}) begin
            bad++;
            $display("FAIL burst_drop: got full/ovf=%b level=%0d want 1%b level=%0d",
                     slv_datard_o[7:6], fifo_level_o, m_ovf, model_level(cyc));
        end
        for (int i = 0; i < 2; i++) begin
            host_read(v, expv);
            total++;
            if (v !== expv) begin
                bad++;
                $display("FAIL burst_read%0d: got %h want %h", i, v, expv);
            end
        end
        wait_strobes("burst", 2 * (Depth + 1), (Depth + 1) * Period + 200);
        check_replay("burst", Depth + 1);
        total++;
        if (fifo_level_o !== 5'(model_level(cyc))) begin
            bad++;
            $display("FAIL burst_empty: got %0d want %0d", fifo_level_o, model_level(cyc));
        end
    endtask

    task automatic test_reset_mid();
        int lim;
        settle();
        for (int i = 0; i < 5; i++) begin
            host_write(1'b0, 8'($urandom));
            host_write(1'b1, 8'($urandom));
        end
        wait_strobes("mid_pairs", 4, 3 * Period);
        lim = cyc + Period;
        while (!(!opm_cs_n && !opm_wr_n && opm_a0) && cyc < lim) @(negedge clk);
        total++;
        if (cyc >= lim) begin
            bad++;
            $display("FAIL mid_data_seen: got timeout want pair 3 data strobe");
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({opm_cs_n, opm_wr_n, fifo_level_o} !== {2'b11, 5'd0}) begin
            bad++;
            $display("FAIL mid_abort: got cs/wr=%b%b level=%0d want 11 level=0",
                     opm_cs_n, opm_wr_n, fifo_level_o);
        end
        reset = 1'b0;
        model_reset();
        repeat (3 * Period) @(negedge clk);
        total++;
        if (strobes.size() != 6 || strobes[5].a0 != 1'b1 || strobes[5].len >= Wp) begin
            bad++;
            $display("FAIL mid_no_more: got %0d strobes want 6 ending in a cut data strobe",
                     strobes.size());
        end
    endtask

    task automatic test_status();
        logic [7:0] v, expv;
        settle();
        opm_status_i = 8'h82;
        @(negedge clk);
        host_read(v, expv);
        total++;
        if (v !== 8'h02) begin
            bad++;
            $display("FAIL status_timer: got %h want %h", v, 8'h02);
        end
        for (int i = 0; i < 4; i++) begin
            opm_status_i = 8'($urandom);
            host_read(v, expv);
            total++;
            if (v !== expv) begin
                bad++;
                $display("FAIL status_rand%0d: got %h want %h", i, v, expv);
            end
        end
        opm_status_i = 8'h80;
    endtask

    task automatic test_busy();
        int p1;
        settle();
        opm_status_i = 8'h80;
        host_write(1'b0, 8'($urandom));
        host_write(1'b1, 8'($urandom));
        host_write(1'b0, 8'($urandom));
        host_write(1'b1, 8'($urandom));
        p1 = pop_e[0];
        // Busy held for the first 100 WAIT cycles, released on the 101st.
        while (cyc < p1 + 3 * Wp + 100) @(negedge clk);
        opm_status_i = 8'h00;
`ifdef FMWQ_BUSY_POLL_EN
        pop_e[1] = p1 + 3 * Wp + 100 + 2;
        last_pop = pop_e[1];
`endif
        wait_strobes("busy", 4, 2 * Period + 50);
        check_replay("busy", 2);
        opm_status_i = 8'h80;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_reset_mid();
        test_status();
        test_busy();
        total++;
        if (skew_seen !== 1'b0) begin
            bad++;
            $display("FAIL strobe_skew: got cs_n/wr_n differing want always equal");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
